// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the 9-bit {carry,out} result type.
// Used by the ALU, its reference model and the result checker.
package alu_pkg;

    localparam int unsigned ResW = 9;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpShl = 3'b101,
        OpShr = 3'b110,
        OpEq  = 3'b111
    } alu_op_e;

    typedef logic [ResW-1:0] alu_res_t;

    typedef enum logic {
        StRun,
        StHalt
    } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: produces the expected {carry,out} for one operation.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [2:0] sel_i,
    output alu_res_t   res_o
);

    always_comb begin
        res_o = '0;
        case (sel_i)
            OpAdd:   res_o = {1'b0, a_i} + {1'b0, b_i};
            // Bit 8 of the 9-bit difference is the borrow (set when a < b).
            OpSub:   res_o = {1'b0, a_i} - {1'b0, b_i};
            OpAnd:   res_o = {1'b0, a_i & b_i};
            OpOr:    res_o = {1'b0, a_i | b_i};
            OpXor:   res_o = {1'b0, a_i ^ b_i};
            OpShl:   res_o = {a_i[7], a_i[6:0], 1'b0};
            OpShr:   res_o = {a_i[0], 1'b0, a_i[7:1]};
            OpEq:    res_o = {8'd0, a_i == b_i};
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_checker.sv
// Scoreboards observed ALU results against alu_ref_model: one-stage compare pipe,
// saturating pass/fail counters, first-failure capture and an optional halt on mismatch.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_a_i,
    input  logic [7:0]       in_b_i,
    input  logic [2:0]       in_sel_i,
    input  logic [7:0]       in_out_i,
    input  logic             in_carry_i,
    input  logic             carry_chk_en_i,
    input  logic             stop_on_fail_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             err_flag_o,
    output logic [7:0]       fail_a_o,
    output logic [7:0]       fail_b_o,
    output logic [2:0]       fail_sel_o,
    output logic [ResW-1:0]  fail_exp_o,
    output logic [ResW-1:0]  fail_got_o,
    output logic             halted_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    chk_state_e       state_q, state_d;
    logic             rdy_en_q;
    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       s1_a_q, s1_b_q;
    logic [2:0]       s1_sel_q;
    alu_res_t         s1_got_q;
    logic             s1_cchk_q;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic             err_q, err_d;
    logic [7:0]       fa_q, fa_d, fb_q, fb_d;
    logic [2:0]       fsel_q, fsel_d;
    alu_res_t         fexp_q, fexp_d, fgot_q, fgot_d;

    alu_res_t s1_exp;
    logic     s1_mismatch;
    logic     stall;
    logic     accept;

    alu_ref_model u_ref (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .sel_i (s1_sel_q),
        .res_o (s1_exp)
    );

    assign s1_mismatch = s1_valid_q &&
                         ((s1_exp[7:0] != s1_got_q[7:0]) ||
                          (s1_cchk_q && (s1_exp[8] != s1_got_q[8])));
    assign stall       = s1_mismatch && stop_on_fail_i;

    // rdy_en_q holds intake off until the first edge after reset release.
    assign in_ready_o = rdy_en_q && !clear_i && (state_q == StRun) && !stall;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d    = state_q;
        s1_valid_d = accept;
        pass_d     = pass_q;
        fail_d     = fail_q;
        err_d      = err_q;
        fa_d       = fa_q;
        fb_d       = fb_q;
        fsel_d     = fsel_q;
        fexp_d     = fexp_q;
        fgot_d     = fgot_q;
        if (clear_i) begin
            state_d    = StRun;
            s1_valid_d = 1'b0;
            pass_d     = '0;
            fail_d     = '0;
            err_d      = 1'b0;
            fa_d       = '0;
            fb_d       = '0;
            fsel_d     = '0;
            fexp_d     = '0;
            fgot_d     = '0;
        end else begin
            if (s1_valid_q) begin
                if (s1_mismatch) begin
                    if (fail_q != CntMax) fail_d = fail_q + 1'b1;
                    if (!err_q) begin
                        err_d  = 1'b1;
                        fa_d   = s1_a_q;
                        fb_d   = s1_b_q;
                        fsel_d = s1_sel_q;
                        fexp_d = s1_exp;
                        fgot_d = s1_got_q;
                    end
                end else if (pass_q != CntMax) begin
                    pass_d = pass_q + 1'b1;
                end
            end
            if (state_q == StRun && stall) state_d = StHalt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            rdy_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sel_q   <= '0;
            s1_got_q   <= '0;
            s1_cchk_q  <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            err_q      <= 1'b0;
            fa_q       <= '0;
            fb_q       <= '0;
            fsel_q     <= '0;
            fexp_q     <= '0;
            fgot_q     <= '0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= 1'b1;
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_a_q    <= in_a_i;
                s1_b_q    <= in_b_i;
                s1_sel_q  <= in_sel_i;
                s1_got_q  <= {in_carry_i, in_out_i};
                s1_cchk_q <= carry_chk_en_i;
            end
            pass_q <= pass_d;
            fail_q <= fail_d;
            err_q  <= err_d;
            fa_q   <= fa_d;
            fb_q   <= fb_d;
            fsel_q <= fsel_d;
            fexp_q <= fexp_d;
            fgot_q <= fgot_d;
        end
    end

    assign pass_cnt_o = pass_q;
    assign fail_cnt_o = fail_q;
    assign err_flag_o = err_q;
    assign fail_a_o   = fa_q;
    assign fail_b_o   = fb_q;
    assign fail_sel_o = fsel_q;
    assign fail_exp_o = fexp_q;
    assign fail_got_o = fgot_q;
    assign halted_o   = (state_q == StHalt);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed plus randomized bench for alu_result_checker against an arithmetic reference model.
module tb_alu_result_checker;

    localparam int CW  = 4;
    localparam int MAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_a = '0, in_b = '0, in_out = '0;
    logic [2:0]    in_sel = '0;
    logic          in_carry = 1'b0, carry_chk_en = 1'b0, stop_on_fail = 1'b0, clear = 1'b0;
    logic [CW-1:0] pass_cnt, fail_cnt;
    logic          err_flag, halted;
    logic [7:0]    fail_a, fail_b;
    logic [2:0]    fail_sel;
    logic [8:0]    fail_exp, fail_got;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_pass, m_fail;
    bit         m_err, m_halt;
    logic [7:0] m_fa, m_fb;
    logic [2:0] m_fsel;
    logic [8:0] m_fexp, m_fgot;

    alu_result_checker #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_a_i         (in_a),
        .in_b_i         (in_b),
        .in_sel_i       (in_sel),
        .in_out_i       (in_out),
        .in_carry_i     (in_carry),
        .carry_chk_en_i (carry_chk_en),
        .stop_on_fail_i (stop_on_fail),
        .clear_i        (clear),
        .pass_cnt_o     (pass_cnt),
        .fail_cnt_o     (fail_cnt),
        .err_flag_o     (err_flag),
        .fail_a_o       (fail_a),
        .fail_b_o       (fail_b),
        .fail_sel_o     (fail_sel),
        .fail_exp_o     (fail_exp),
        .fail_got_o     (fail_got),
        .halted_o       (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] golden(input int a, input int b, input int sel);
        int o;
        int c;
        c = 0;
        case (sel)
            0: begin o = a + b; c = (o > 255) ? 1 : 0; end
            1: begin o = a - b; c = (a < b) ? 1 : 0; end
            2: o = a & b;
            3: o = a | b;
            4: o = a ^ b;
            5: begin o = a * 2; c = a / 128; end
            6: begin o = a / 2; c = a % 2; end
            default: o = (a == b) ? 1 : 0;
        endcase
        return {c[0], o[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_zero();
        m_pass = 0; m_fail = 0; m_err = 0; m_halt = 0;
        m_fa = '0; m_fb = '0; m_fsel = '0; m_fexp = '0; m_fgot = '0;
    endtask

    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                                input logic [7:0] o, input logic c, input logic cchk);
        logic [8:0] e;
        bit mm;
        e  = golden(int'(a), int'(b), int'(sel));
        mm = (e[7:0] != o) || (cchk && (e[8] != c));
        if (mm) begin
            if (m_fail < MAX) m_fail++;
            if (!m_err) begin
                m_err = 1; m_fa = a; m_fb = b; m_fsel = sel; m_fexp = e; m_fgot = {c, o};
            end
            if (stop_on_fail) m_halt = 1;
        end else if (m_pass < MAX) begin
            m_pass++;
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                        input logic [7:0] o, input logic c, input logic cchk);
        logic rdy;
        in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel;
        in_out = o; in_carry = c; carry_chk_en = cchk;
        #3 rdy = in_ready;
        check("in_ready", rdy, !m_halt);
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (rdy) model_accept(a, b, sel, o, c, cchk);
    endtask

    task automatic send_good(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        logic [8:0] e;
        e = golden(int'(a), int'(b), int'(sel));
        send(a, b, sel, e[7:0], e[8], 1'b1);
    endtask

    task automatic send_rand();
        logic [7:0] a, b, o;
        logic [2:0] sel;
        logic [8:0] e;
        logic c;
        int mode;
        a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom);
        e = golden(int'(a), int'(b), int'(sel));
        o = e[7:0]; c = e[8];
        mode = $urandom_range(0, 2);
        if (mode == 1) o = o ^ 8'($urandom_range(1, 255));
        if (mode == 2) c = ~c;
        send(a, b, sel, o, c, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #3 check("ready_during_clear", in_ready, 0);
        @(posedge clk);
        #1 clear = 1'b0;
        model_zero();
    endtask

    task automatic drain_check(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".pass_cnt"}, pass_cnt, m_pass);
        check({tag, ".fail_cnt"}, fail_cnt, m_fail);
        check({tag, ".err_flag"}, err_flag, m_err);
        check({tag, ".halted"}, halted, m_halt);
        check({tag, ".fail_a"}, fail_a, m_fa);
        check({tag, ".fail_b"}, fail_b, m_fb);
        check({tag, ".fail_sel"}, fail_sel, m_fsel);
        check({tag, ".fail_exp"}, fail_exp, m_fexp);
        check({tag, ".fail_got"}, fail_got, m_fgot);
    endtask

    initial begin
        model_zero();
        // Reset state
        #2;
        check("rst.in_ready", in_ready, 0);
        check("rst.pass_cnt", pass_cnt, 0);
        check("rst.fail_cnt", fail_cnt, 0);
        check("rst.err_flag", err_flag, 0);
        check("rst.halted", halted, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2 check("ready_before_first_edge", in_ready, 0);
        @(posedge clk);
        #1 check("ready_after_first_edge", in_ready, 1);

        // All opcodes, A=10 B=5, correct results
        for (int s = 0; s < 8; s++) send_good(8'd10, 8'd5, 3'(s));
        drain_check("allops");
        check("allops.pass_const", pass_cnt, 8);

        // Carry compare with overflowing add
        do_clear();
        send(8'd200, 8'd100, 3'd0, 8'd44, 1'b1, 1'b1);
        send(8'd200, 8'd100, 3'd0, 8'd44, 1'b0, 1'b1);
        drain_check("carry");
        check("carry.fail_exp_const", fail_exp, 9'h12C);
        check("carry.fail_got_const", fail_got, 9'h02C);

        // Carry ignored when carry_chk_en=0
        do_clear();
        send(8'd200, 8'd100, 3'd0, 8'd44, 1'b0, 1'b0);
        drain_check("carry_off");

        // Two consecutive mismatches keep the first capture
        do_clear();
        send(8'd3, 8'd4, 3'd0, 8'd0, 1'b0, 1'b1);
        send(8'd9, 8'd9, 3'd7, 8'd5, 1'b0, 1'b1);
        drain_check("two_fail");
        check("two_fail.fail_a_const", fail_a, 3);

        // Stop on third of five back-to-back transactions
        do_clear();
        stop_on_fail = 1'b1;
        send_good(8'd1, 8'd2, 3'd0);
        send_good(8'd7, 8'd3, 3'd1);
        send(8'd5, 8'd5, 3'd2, 8'd1, 1'b0, 1'b1);
        send_good(8'd6, 8'd6, 3'd7);
        send_good(8'd8, 8'd1, 3'd3);
        drain_check("halt");
        check("halt.halted_const", halted, 1);
        do_clear();
        drain_check("halt_clear");
        stop_on_fail = 1'b0;

        // Saturation with 20 passes
        for (int i = 0; i < 20; i++) send_good(8'($urandom), 8'($urandom), 3'($urandom));
        drain_check("sat");
        check("sat.pass_const", pass_cnt, 15);

        // Clear on the cycle s1 holds a result
        do_clear();
        send_good(8'd4, 8'd4, 3'd0);
        do_clear();
        drain_check("clear_pending");

        // Randomized mixes, without and with stop-on-fail
        for (int i = 0; i < 14; i++) send_rand();
        drain_check("rand_run");
        do_clear();
        stop_on_fail = 1'b1;
        for (int i = 0; i < 14; i++) send_rand();
        drain_check("rand_stop");
        do_clear();
        stop_on_fail = 1'b0;

        // Asynchronous reset with s1 valid
        send(8'd1, 8'd1, 3'd4, 8'd7, 1'b0, 1'b1);
        send_good(8'd2, 8'd3, 3'd0);
        send_good(8'd9, 8'd3, 3'd5);
        #2 rst_n = 1'b0;
        #1;
        check("async.pass_cnt", pass_cnt, 0);
        check("async.fail_cnt", fail_cnt, 0);
        check("async.err_flag", err_flag, 0);
        check("async.fail_got", fail_got, 0);
        check("async.in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_zero();
        drain_check("async_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 Parameter CNT_W, default 16, width of the pass and fail counters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  an ALU transaction is presented.
REQ-005 in_ready  output  1  checker accepts the transaction on this cycle.
REQ-006 in_a, in_b  input  8 each  ALU operands.
REQ-007 in_sel  input  3  ALU opcode.
REQ-008 in_out, in_carry  input  8, 1  observed ALU_Out and CarryOut.
REQ-009 carry_chk_en  input  1  1 = include carry in compare; 0 = ignore carry.
REQ-010 stop_on_fail  input  1  1 = halt intake on first mismatch.
REQ-011 clear  input  1  synchronous clear of counters, error capture and halt.
REQ-012 pass_cnt, fail_cnt  output  CNT_W each  saturating result counters.
REQ-013 err_flag  output  1  sticky: at least one mismatch since reset/clear.
REQ-014 fail_a, fail_b, fail_sel  output  8, 8, 3  operands/opcode of first mismatch.
REQ-015 fail_exp, fail_got  output  9 each  {carry,out} expected/observed of first mismatch.
REQ-016 halted  output  1  checker is in HALT state.

Function
REQ-017 Transfer occurs on a rising edge where in_valid and in_ready are both 1; the transaction is registered into the compare stage (s1).
REQ-018 Expected result per opcode, 9-bit {carry,out}: 000 A+B (carry = bit 8); 001 A-B (carry = borrow, 1 when A<B); 010 A&B; 011 A|B; 100 A^B (carry 0 for 010-100); 101 A<<1, carry = A[7]; 110 A>>1, carry = A[0]; 111 out = 8'd1 if A==B else 8'd0, carry 0.
REQ-019 Mismatch = out differs, or (carry_chk_en and carry differs); carry_chk_en is sampled together with the transaction.
REQ-020 One cycle after transfer, the s1 result updates exactly one counter: pass_cnt on match, fail_cnt on mismatch.
REQ-021 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-022 On a mismatch with err_flag=0: set err_flag and load fail_* registers; later mismatches leave fail_* unchanged.
REQ-023 FSM states RUN, HALT; RUN->HALT when s1 holds a mismatch and stop_on_fail=1; HALT->RUN only on clear.
REQ-024 in_ready = 1 in RUN except when s1 holds a mismatch and stop_on_fail=1 (combinational, so no transaction is accepted after the failing one); in_ready = 0 in HALT.
REQ-025 Back-to-back transfers are accepted every cycle in RUN (throughput 1 per cycle).
REQ-026 clear has priority over everything else: zero both counters, err_flag and fail_*; s1 is invalidated (in-flight result discarded, no count); state becomes RUN; in_ready = 0 during the clear cycle.

Reset
REQ-027 rst_n low asynchronously forces: state RUN, s1 invalid, pass_cnt=0, fail_cnt=0, err_flag=0, fail_*=0, halted=0.
REQ-028 in_ready = 0 while rst_n is low; it rises after the first clock edge following deassertion.
REQ-029 Reset asserted mid-transaction discards the in-flight transaction without counting it.

Structure
REQ-030 Opcode constants (ADD, SUB, AND, OR, XOR, SHL, SHR, EQ) and the 9-bit result width live in a shared package (alu_pkg), also used by the ALU itself.
REQ-031 The golden model is a combinational sub-module alu_ref_model (A, B, sel -> 9-bit {carry,out}); FSM, counters and capture logic stay in alu_result_checker.

Verification
REQ-032 A=10, B=5 with sel 000..111 and correct outputs (15,5,0,15,15,20,5,0, carry 0): pass_cnt=8, fail_cnt=0, err_flag=0.
REQ-033 A=200, B=100, sel 000, in_out=44, in_carry=1 with carry_chk_en=1: pass; same with in_carry=0: fail, fail_exp=9'h12C, fail_got=9'h02C.
REQ-034 stop_on_fail=1, fail on the 3rd of 5 back-to-back transactions: in_ready drops the cycle after its transfer, halted=1, pass_cnt=2, fail_cnt=1; clear then returns to RUN with all counters 0.
REQ-035 Two mismatches in a row (stop_on_fail=0): fail_cnt=2, fail_* hold the first one.
REQ-036 With CNT_W=4, 20 passing transactions: pass_cnt=15 (saturated); clear asserted on the same cycle as a pending s1 result: counters 0, no count.
REQ-037 rst_n pulsed low between edges with s1 valid: all outputs 0 immediately, transaction never counted.
